// File: rtl/instr_enc_pkg.sv
// Shared encodings for the instruction-memory loader: descriptor kinds,
// MIPS opcode/funct constants, FSM state codes and word-packing helpers.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    K_ADD = 4'd0,
    K_SUB = 4'd1,
    K_AND = 4'd2,
    K_OR  = 4'd3,
    K_SLT = 4'd4,
    K_LW  = 4'd5,
    K_SW  = 4'd6,
    K_BEQ = 4'd7,
    K_J   = 4'd8
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: descriptor kind + fields -> 32-bit MIPS word.
// Illegal kinds produce an all-zero word with the illegal flag raised.
module instr_pack
  import instr_enc_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      K_ADD:   word = rtype(rs, rt, rd, FN_ADD);
      K_SUB:   word = rtype(rs, rt, rd, FN_SUB);
      K_AND:   word = rtype(rs, rt, rd, FN_AND);
      K_OR:    word = rtype(rs, rt, rd, FN_OR);
      K_SLT:   word = rtype(rs, rt, rd, FN_SLT);
      K_LW:    word = itype(OP_LW,  rs, rt, imm);
      K_SW:    word = itype(OP_SW,  rs, rt, imm);
      K_BEQ:   word = itype(OP_BEQ, rs, rt, imm);
      K_J:     word = {OP_J, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instruction words into instruction memory through a
// one-deep output register. Optional INSTR_ENC_CHECK_EN drops illegal kinds and flags err.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        state;
  logic [AW-1:0] cnt;
  logic [31:0]   word;
  logic          illegal;
  logic          drain_ok;
  logic          accept;
  logic          wr_done;
  logic          load;

  instr_pack u_pack (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .target  (in_target),
    .word    (word),
    .illegal (illegal)
  );

  // Output register is free when empty or emptying this cycle.
  assign drain_ok = !mem_we || mem_ready;
  assign in_ready = (state == ST_RUN) && drain_ok;
  assign accept   = in_valid && in_ready;
  assign wr_done  = mem_we && mem_ready;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FLUSH) && drain_ok;
  assign mem_addr = cnt;

`ifdef INSTR_ENC_CHECK_EN
  logic err_q;
  assign load = accept && !illegal;
  assign err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 err_q <= 1'b0;
    else if (accept && illegal) err_q <= 1'b1;
  end
`else
  assign load = accept;
  assign err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (start) state <= ST_RUN;
        ST_RUN:   if (accept && in_last) state <= ST_FLUSH;
        ST_FLUSH: if (drain_ok) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      // Address only moves on a completed write, so dropped words leave no hole.
      if (state == ST_IDLE && start) cnt <= start_addr;
      else if (wr_done)              cnt <= cnt + AW'(1);

      if (load) begin
        mem_we    <= 1'b1;
        mem_wdata <= illegal ? 32'h0 : word;
      end else if (wr_done) begin
        mem_we    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter AW, default 10: instruction-memory word-address width.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  one-cycle pulse: begin a load session at start_addr.
REQ-005 start_addr  in  AW  first word address of the session.
REQ-006 in_valid  in  1  instruction descriptor present.
REQ-007 in_ready  out  1  encoder accepts the descriptor this cycle.
REQ-008 in_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 J; 9-15 illegal.
REQ-009 in_rs, in_rt, in_rd  in  5 each  register fields.
REQ-010 in_imm  in  16  immediate / branch offset; in_target  in  26  jump target.
REQ-011 in_last  in  1  marks the final descriptor of the session.
REQ-012 mem_we  out  1  write request to instruction memory.
REQ-013 mem_addr  out  AW; mem_wdata  out  32; mem_ready  in  1  memory accepts.
REQ-014 busy  out  1; done  out  1 (one-cycle pulse); err  out  1 (sticky).

Function
REQ-015 The R-type word SHALL be {6'h00, rs, rt, rd, 5'h00, funct}, with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
REQ-016 The I-type word SHALL be {op, rs, rt, imm}, with op LW 0x23, SW 0x2B, BEQ 0x04; in_rd ignored.
REQ-017 The J word SHALL be {6'h02, target}; other fields ignored.
REQ-018 The FSM SHALL have states IDLE, RUN and FLUSH; start moves IDLE->RUN and loads the address counter with start_addr; start outside IDLE is ignored.
REQ-019 In RUN, a descriptor is accepted when in_valid && in_ready; the encoded word enters a one-deep output register in the same edge (latency 1 cycle to mem_we).
REQ-020 in_ready SHALL equal (state==RUN) && (!mem_we || mem_ready), so simultaneous drain and refill sustains 1 word/cycle.
REQ-021 mem_we SHALL hold, with mem_addr/mem_wdata stable, until mem_ready is high; the address counter increments on each completed write.
REQ-022 The address counter SHALL wrap from 2^AW-1 to 0 without error.
REQ-023 Acceptance of in_last SHALL move RUN->FLUSH; FLUSH->IDLE occurs on completion of the last write, with done pulsed in that same cycle.
REQ-024 busy SHALL be 1 in RUN and FLUSH.
REQ-025 Descriptors with in_valid outside RUN SHALL NOT be accepted (in_ready=0).

Reset
REQ-026 rst_n low SHALL immediately force IDLE and clear mem_we, done, err and busy to 0; mem_addr, mem_wdata and the counter SHALL reset to 0.
REQ-027 Reset mid-session SHALL discard any pending word; no write completes after reset asserts.

Configuration
REQ-028 Macro INSTR_ENC_CHECK_EN: when defined, an illegal in_kind is accepted, not written, sets err, and does not advance the address; with in_last, the session still ends through FLUSH/done.
REQ-029 When INSTR_ENC_CHECK_EN is undefined, an illegal kind SHALL be written as 32'h00000000, and err SHALL be tied to 0.

Structure
REQ-030 Package instr_enc_pkg SHALL hold the kind enumeration, opcode and funct constants, and the FSM state type.
REQ-031 Combinational field packing SHALL be sub-module instr_pack (kind and fields in -> 32-bit word plus illegal flag out); the FSM, counter and output register live in instr_encoder.

Verification
REQ-032 start_addr=0x010, ADD rs=1 rt=2 rd=3 with in_last, mem_ready=1 -> one write of 0x00221820 to 0x010, then done pulses.
REQ-033 LW rs=0 rt=8 imm=4, then BEQ rs=1 rt=2 imm=0xFFFF, then J target=0x10 (last), back-to-back -> 0x8C080004, 0x1022FFFF, 0x08000010 at consecutive addresses, 1 word/cycle.
REQ-034 mem_ready held low 3 cycles -> mem_we, mem_addr and mem_wdata held stable, in_ready=0, no descriptor lost.
REQ-035 start_addr=0x3FF, two descriptors -> writes to 0x3FF then 0x000.
REQ-036 in_kind=12 with INSTR_ENC_CHECK_EN defined -> no write, err=1, next legal word takes the unadvanced address; without the macro -> 0x00000000 is written.
REQ-037 rst_n low while mem_we pending -> mem_we drops immediately, state IDLE, done is not pulsed.
